// File: rtl/matmul_feeder_if.sv
// Host-side write/start port and MAC-array operand bus of the matmul feeder.
// master = host/array side, slave = the feeder itself.
interface matmul_feeder_if #(
    parameter int DW = 4
);
    logic          wr_en;
    logic          wr_sel;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] data_w1, data_w2, data_w3;
    logic [DW-1:0] data_x1, data_x2, data_x3;
    logic          load;
    logic          clear;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, err, load, clear,
        input  data_w1, data_w2, data_w3, data_x1, data_x2, data_x3
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, err, load, clear,
        output data_w1, data_w2, data_w3, data_x1, data_x2, data_x3
    );
endinterface

// File: rtl/matmul_feeder.sv
// Operand sequencer for the 3x3 MAC array: stores W and X, then issues one
// clear cycle and three load cycles presenting column k of W and row k of X.
//
// state | meaning
// IDLE  | accepts writes and start
// CLR   | clear pulse to the array
// ACC   | load high, buses carry step r_k (0..2)
// DONE  | done pulse, array results final
module matmul_feeder #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    matmul_feeder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLR, ACC, DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_k;
    logic          r_busy, r_done, r_err, r_load, r_clear;
    logic [DW-1:0] r_w [9];
    logic [DW-1:0] r_x [9];
    logic [DW-1:0] r_dw [3];
    logic [DW-1:0] r_dx [3];

    logic          w_wr_ok, w_wr_bad, w_start;
    logic [1:0]    w_k_nxt;
    logic [3:0]    w_k3;
    logic [DW-1:0] w_opw [3];
    logic [DW-1:0] w_opx [3];

    assign w_wr_ok  = bus.wr_en && (r_state == IDLE) && (bus.wr_addr <= 4'd8);
    assign w_wr_bad = bus.wr_en && !w_wr_ok;
    assign w_start  = (r_state == IDLE) && bus.start;

    // Step presented in the next cycle; 3 means "no step", buses go to zero.
    always_comb begin
        w_k_nxt = 2'd3;
        if (r_state == CLR)
            w_k_nxt = 2'd0;
        else if (r_state == ACC)
            w_k_nxt = r_k + 2'd1;
    end

    assign w_k3 = {2'b00, w_k_nxt} + {1'b0, w_k_nxt, 1'b0};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_opw[i] = '0;
            w_opx[i] = '0;
        end
        if (w_k_nxt != 2'd3) begin
            for (int i = 0; i < 3; i++) begin
                w_opw[i] = r_w[4'(i * 3) + {2'b00, w_k_nxt}];
                w_opx[i] = r_x[w_k3 + 4'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_w[i] <= '0;
                r_x[i] <= '0;
            end
        end else if (w_wr_ok) begin
            if (bus.wr_sel)
                r_x[bus.wr_addr] <= bus.wr_data;
            else
                r_w[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
            r_clear <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_dw[i] <= '0;
                r_dx[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_dw[i] <= w_opw[i];
                r_dx[i] <= w_opx[i];
            end
            // A bad write in the same cycle as an accepted start still flags.
            if (w_wr_bad)
                r_err <= 1'b1;
            else if (w_start)
                r_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= CLR;
                        r_busy  <= 1'b1;
                        r_clear <= 1'b1;
                    end
                end
                CLR: begin
                    r_state <= ACC;
                    r_clear <= 1'b0;
                    r_load  <= 1'b1;
                    r_k     <= 2'd0;
                end
                ACC: begin
                    if (r_k == 2'd2) begin
                        r_state <= DONE;
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                        r_k     <= 2'd0;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.load    = r_load;
    assign bus.clear   = r_clear;
    assign bus.data_w1 = r_dw[0];
    assign bus.data_w2 = r_dw[1];
    assign bus.data_w3 = r_dw[2];
    assign bus.data_x1 = r_dx[0];
    assign bus.data_x2 = r_dx[1];
    assign bus.data_x3 = r_dx[2];
endmodule

// File: doc/matmul_feeder.md
# matmul_feeder

Operand sequencer that drives the 3x3 MAC-array matrix multiplier. Host logic writes two 3x3 matrices, W and X, of DW-bit elements into internal storage. A start pulse then makes the block issue one clear cycle followed by three load cycles, presenting column k of W and row k of X on the array's operand buses. When the sequence ends, every array cell m_ij holds C[i][j] = sum over k of W[i][k]*X[k][j]. The block sits between the host register interface and the array, and is the only driver of the array's data_w*, data_x*, load and clear inputs.

## Interface
- DW, 4, element width; the array's 10-bit accumulators hold 3*(2^DW-1)^2 only for DW <= 4
- clk  in  1  rising-edge clock, shared with the array
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one matrix element this cycle
- wr_sel  in  1  0 = write W, 1 = write X
- wr_addr  in  4  element index row*3+col; legal range 0..8
- wr_data  in  DW  element value, unsigned
- start  in  1  begin a multiply; sampled only in IDLE
- busy  out  1  high in CLR, ACC and DONE
- done  out  1  one-cycle pulse; array results are final while high
- err  out  1  sticky; set by an illegal or ignored write, cleared by an accepted start
- data_w1, data_w2, data_w3  out  DW  W[0][k], W[1][k], W[2][k]
- data_x1, data_x2, data_x3  out  DW  X[k][0], X[k][1], X[k][2]
- load  out  1  array accumulate enable
- clear  out  1  array accumulator clear

## Operation
- Storage: two banks of 9 x DW-bit registers. Reset clears both banks to 0.
- Write in IDLE with wr_addr <= 8: stores wr_data at bank[wr_sel][wr_addr] on the clock edge.
- Write with wr_addr 9..15, or any write while busy: storage unchanged, err set.
- FSM states IDLE, CLR, ACC, DONE. Step counter k is 2 bits.
- IDLE: start=1 -> CLR. Otherwise remain in IDLE.
- CLR: clear=1, load=0 -> ACC with k=0.
- ACC: load=1. Operand buses carry step k. k increments every cycle. After k=2 -> DONE.
- DONE: done=1, load=0 -> IDLE.
- Operand buses are 0 outside ACC. clear and load are never high together.
- start while busy is ignored and does not set err.
- Write and start in the same IDLE cycle: the write commits and is included in the computation.
- Writes are accepted again in the DONE cycle? No: DONE counts as busy, so writes there are ignored and set err.
- Arithmetic is owned by the array. The feeder only orders operands. The maximum result for DW=4 is 3*15*15 = 675.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Timing
- Reset values: busy=0, done=0, err=0, load=0, clear=0, all data_* = 0, state IDLE, k=0.
- Reset is asynchronous: rst_n low forces these values immediately, regardless of clk.
- Start accepted at edge t:
  - clear high in cycle t+1
  - load high in cycles t+2, t+3, t+4, with k = 0, 1, 2
  - done high in cycle t+5
  - IDLE again from t+6
- Start-to-done latency is 5 cycles. Minimum start-to-start spacing is 6 cycles.
- busy rises in cycle t+1 and falls at the end of cycle t+5.
- Reset mid-operation: the sequence aborts and outputs return to reset values. Partial array contents are invalid. The next start re-clears the array.
- Stored matrices persist across operations. Only reset clears them.

## Test plan
- Reset: assert rst_n low mid-cycle -> every output is 0 without waiting for a clock edge; the FSM is in IDLE.
- Identity: W = I, X = 1..9 row-major, then start -> load asserts for exactly 3 cycles, data_x rows follow (1,2,3), (4,5,6), (7,8,9), and the array reads C = X at done.
- Full scale: all elements = 15 -> all nine results = 675. All elements = 3 -> all nine results = 27.
- Latency: start at edge t -> clear only at t+1, load at t+2..t+4, done at t+5 only. A second start pulsed at t+2 has no effect.
- Illegal writes: wr_addr = 9, and separately a write during ACC -> err = 1 and the stored matrices are unchanged. The next accepted start clears err.
- Abort: rst_n low during k=1 -> load = 0 at once and the FSM is in IDLE. A fresh start then produces correct results, with clear preceding the load cycles.
